// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Digit width, FSM state encoding and a digit-count sizing helper.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

  // floor(width*log10(2)) + 1 digits hold 2**width-1
  function automatic int bcd_digits_for(int width);
    return (width * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// Double-dabble digit correction: add 3 to a BCD digit >= 5
// so the following left shift carries correctly into the next digit.
module bcd_add3_cell
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  // correct a single digit ahead of the shift
  always_comb begin
    dout = din;
    if (din >= 4'd5)
      dout = din + 4'd3;
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Optional macro BCD_OVF_EN adds a sticky truncation flag on port overflow.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          ready,
  output logic                          valid,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
`ifdef BCD_OVF_EN
  ,
  output logic                          overflow
`endif
);

  localparam int NW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  bcd_state_t state_q, state_d;
  logic accept, last;

  logic [BIN_W-1:0] bin_q;
  logic [NW-1:0]    dig_q;
  logic [NW-1:0]    corr;
  logic [NW-1:0]    dig_nxt;
  logic [CW-1:0]    cnt_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_cell
    bcd_add3_cell u_cell (
      .din  (dig_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign dig_nxt = {corr[NW-2:0], bin_q[BIN_W-1]};

`ifdef BCD_OVF_EN
  logic lost, ovf_q;
  assign lost = corr[NW-1];
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // next state and handshake outputs
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    ready   = 1'b1;
    valid   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ready = 1'b0;
        if (cnt_q == CW'(1)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        valid = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // operand load, shift/correct datapath and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q   <= '0;
      dig_q   <= '0;
      cnt_q   <= '0;
      bcd_out <= '0;
`ifdef BCD_OVF_EN
      ovf_q    <= 1'b0;
      overflow <= 1'b0;
`endif
    end else if (accept) begin
      bin_q <= bin_in;
      dig_q <= '0;
      cnt_q <= CW'(BIN_W);
`ifdef BCD_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (state_q == SHIFT) begin
      bin_q <= bin_q << 1;
      dig_q <= dig_nxt;
      cnt_q <= cnt_q - CW'(1);
`ifdef BCD_OVF_EN
      ovf_q <= ovf_q | lost;
      if (last)
        overflow <= ovf_q | lost;
`endif
      if (last)
        bcd_out <= dig_nxt;
    end
  end

endmodule
